// File: rtl/channel_narrow_pkg.sv
// channel_narrow_pkg
//   Shared sizing helpers for the channel_narrow slice serializer.
//   divisions : number of narrow slices needed to carry one wide word
//   cnt_width : width of the slice counter (never narrower than 1 bit)
package channel_narrow_pkg;

  // Ceiling division: how many out-width slices cover an in-width word.
  function automatic int divisions(input int in_w, input int out_w);
    return (in_w + out_w - 1) / out_w;
  endfunction

  // Counter width for a modulo-div counter; a 1-slice channel still gets 1 bit.
  function automatic int cnt_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/channel_narrow_ctr.sv
// channel_narrow_ctr
//   Modulo-DIV_P up-counter that tracks which slice of the wide word is
//   currently presented. Advances on en_i, wraps after DIV_P-1.
// Ports
//   clk    : clock
//   reset  : synchronous, active-high reset (counter -> 0)
//   en_i   : advance the counter this cycle (consumer dequeue)
//   cnt_o  : current slice count
//   last_o : high while the count sits on the final slice (DIV_P-1)
import channel_narrow_pkg::*;

module channel_narrow_ctr #(
  parameter int DIV_P   = 4,
  parameter int CNT_W_P = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  output logic [CNT_W_P-1:0] cnt_o,
  output logic               last_o
);

  localparam logic [CNT_W_P-1:0] LastCnt = CNT_W_P'(DIV_P - 1);

  logic [CNT_W_P-1:0] r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == LastCnt);

  // Wrap to zero on the final slice so the next word starts at slice 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (en_i) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cnt_o  = r_cnt;
  assign last_o = w_last;

endmodule

// File: rtl/channel_narrow.sv
// channel_narrow
//   Serializes one wide word into ceil(width_in_p/width_out_p) narrow slices
//   on a consume-driven channel. Routing is purely combinational; only the
//   slice counter is registered. The producer must hold data_i stable until
//   deque_o pulses on the final slice.
// Parameters
//   width_in_p   : wide input word width (>=1)
//   width_out_p  : narrow slice width (>=1)
//   lsb_to_msb_p : 1 = least-significant slice first, 0 = most-significant first
// Ports
//   clk     : clock
//   reset   : synchronous, active-high reset
//   data_i  : wide word from the producer
//   deque_i : consumer takes the current slice this cycle
//   data_o  : current slice (combinational)
//   deque_o : wide word fully consumed; producer advances next cycle
// Configuration
//   CHANNEL_NARROW_CHECK_EN : when defined, compiles in simulation-only checks
//   (parameter sanity, X on deque_i, data_i changing mid-word).
import channel_narrow_pkg::*;

module channel_narrow #(
  parameter int width_in_p   = 8,
  parameter int width_out_p  = 2,
  parameter int lsb_to_msb_p = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [width_in_p-1:0]  data_i,
  input  logic                   deque_i,
  output logic [width_out_p-1:0] data_o,
  output logic                   deque_o
);

  localparam int Div   = divisions(width_in_p, width_out_p);
  localparam int CntW  = cnt_width(Div);
  localparam int PadW  = Div * width_out_p;

  // Zero-extend at the MSB so every slice is full width.
  logic [PadW-1:0] w_padded;
  assign w_padded = PadW'(data_i);

  generate
    if (Div == 1) begin : g_bypass
      // Word fits in one slice: no counter, every dequeue completes the word.
      assign data_o  = w_padded;
      assign deque_o = deque_i & ~reset;
    end else begin : g_serial
      localparam logic [CntW-1:0] LastIdx = CntW'(Div - 1);

      logic [Div-1:0][width_out_p-1:0] w_slices;
      logic [CntW-1:0]                 w_cnt;
      logic [CntW-1:0]                 w_cnt_eff;
      logic [CntW-1:0]                 w_sel;
      logic                            w_last;

      channel_narrow_ctr #(
        .DIV_P   (Div),
        .CNT_W_P (CntW)
      ) u_ctr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (deque_i),
        .cnt_o  (w_cnt),
        .last_o (w_last)
      );

      assign w_slices = w_padded;

      // Reset is synchronous, so the counter may still hold old progress in
      // the reset cycle; force slice 0 of the current ordering while reset is high.
      assign w_cnt_eff = reset ? '0 : w_cnt;
      assign w_sel     = (lsb_to_msb_p != 0) ? w_cnt_eff : (LastIdx - w_cnt_eff);

      assign data_o  = w_slices[w_sel];
      assign deque_o = deque_i & w_last & ~reset;

`ifdef CHANNEL_NARROW_CHECK_EN
      logic [width_in_p-1:0] r_prev_data;

      always_ff @(posedge clk) begin
        r_prev_data <= data_i;
      end

      // Mid-word the producer must keep the word stable, and deque_i must be known.
      always @(posedge clk) begin
        if (!reset) begin
          if ($isunknown(deque_i)) begin
            $error("channel_narrow: deque_i is X/Z");
          end
          if ((w_cnt != '0) && (data_i != r_prev_data)) begin
            $error("channel_narrow: data_i changed while word partially consumed");
          end
        end
      end
`endif
    end
  endgenerate

`ifdef CHANNEL_NARROW_CHECK_EN
  generate
    if (width_in_p < 1 || width_out_p < 1) begin : g_bad_param
      $error("channel_narrow: width_in_p and width_out_p must be >= 1");
    end
  endgenerate
`else
  // Checks are compiled out; datapath is unchanged.
`endif

endmodule

// File: tb/tb_channel_narrow.sv
// tb_channel_narrow
//   Drives five channel_narrow configurations side by side from one shared
//   reset/deque stream and compares every output against hand-computed
//   vectors, then runs a reset-mid-word recovery sequence.
module tb_channel_narrow;

  logic       clk;
  logic       reset;
  logic       deque;
  logic [2:0] d3;
  logic [7:0] d8;
  logic [1:0] d2;

  logic [1:0] o3l, o3m, o8l, o8m;
  logic [2:0] o2;
  logic       q3l, q3m, q8l, q8m, q2;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  channel_narrow #(.width_in_p(3), .width_out_p(2), .lsb_to_msb_p(1)) u3l (
    .clk(clk), .reset(reset), .data_i(d3), .deque_i(deque), .data_o(o3l), .deque_o(q3l));
  channel_narrow #(.width_in_p(3), .width_out_p(2), .lsb_to_msb_p(0)) u3m (
    .clk(clk), .reset(reset), .data_i(d3), .deque_i(deque), .data_o(o3m), .deque_o(q3m));
  channel_narrow #(.width_in_p(8), .width_out_p(2), .lsb_to_msb_p(1)) u8l (
    .clk(clk), .reset(reset), .data_i(d8), .deque_i(deque), .data_o(o8l), .deque_o(q8l));
  channel_narrow #(.width_in_p(8), .width_out_p(2), .lsb_to_msb_p(0)) u8m (
    .clk(clk), .reset(reset), .data_i(d8), .deque_i(deque), .data_o(o8m), .deque_o(q8m));
  channel_narrow #(.width_in_p(2), .width_out_p(3), .lsb_to_msb_p(1)) u2 (
    .clk(clk), .reset(reset), .data_i(d2), .deque_i(deque), .data_o(o2), .deque_o(q2));

  typedef struct {
    logic       rst;
    logic       deq;
    logic [2:0] d3;
    logic [7:0] d8;
    logic [1:0] d2;
    logic [1:0] e3l;
    logic [1:0] e3m;
    logic [1:0] e8l;
    logic [1:0] e8m;
    logic [2:0] e2;
    logic [4:0] eq;   // expected deque_o: {3l, 3m, 8l, 8m, 2}
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic deq, input logic [2:0] a3,
                        input logic [7:0] a8, input logic [1:0] a2,
                        input logic [1:0] e3l, input logic [1:0] e3m,
                        input logic [1:0] e8l, input logic [1:0] e8m,
                        input logic [2:0] e2, input logic [4:0] eq);
    vec_t v;
    v.rst = rst; v.deq = deq; v.d3 = a3; v.d8 = a8; v.d2 = a2;
    v.e3l = e3l; v.e3m = e3m; v.e8l = e8l; v.e8m = e8m; v.e2 = e2; v.eq = eq;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    deque = v.deq;
    d3    = v.d3;
    d8    = v.d8;
    d2    = v.d2;
  endtask

  initial begin
    int n;
    bit seen;

    reset = 1'b1; deque = 1'b0; d3 = '0; d8 = '0; d2 = '0;

    // rst deq  d3      d8     d2     3l     3m     8l     8m     2       deque_o
    addVec(1, 1, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 3'b011, 5'b00000);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 3'b011, 5'b00001);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 3'b011, 5'b11001);
    addVec(0, 0, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 3'b011, 5'b00000);
    addVec(0, 0, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 3'b011, 5'b00000);
    addVec(0, 0, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 3'b011, 5'b00000);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 3'b011, 5'b00001);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 3'b011, 5'b11111);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 3'b011, 5'b00001);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 3'b011, 5'b11001);
    addVec(1, 1, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 3'b011, 5'b00000);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 3'b011, 5'b00001);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 3'b011, 5'b11001);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b10, 2'b01, 2'b11, 2'b01, 3'b011, 5'b00001);
    addVec(0, 1, 3'b110, 8'hB4, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00, 3'b011, 5'b11111);
    addVec(0, 0, 3'b011, 8'h1E, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 3'b001, 5'b00000);
    addVec(0, 1, 3'b011, 8'h1E, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 3'b001, 5'b00001);
    addVec(0, 1, 3'b011, 8'h1E, 2'b01, 2'b00, 2'b11, 2'b11, 2'b01, 3'b001, 5'b11001);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d data3l", i), {6'b0, o3l}, {6'b0, vecs[i].e3l});
      checkOutput($sformatf("v%0d data3m", i), {6'b0, o3m}, {6'b0, vecs[i].e3m});
      checkOutput($sformatf("v%0d data8l", i), {6'b0, o8l}, {6'b0, vecs[i].e8l});
      checkOutput($sformatf("v%0d data8m", i), {6'b0, o8m}, {6'b0, vecs[i].e8m});
      checkOutput($sformatf("v%0d data2", i),  {5'b0, o2},  {5'b0, vecs[i].e2});
      checkOutput($sformatf("v%0d deque3l", i), {7'b0, q3l}, {7'b0, vecs[i].eq[4]});
      checkOutput($sformatf("v%0d deque3m", i), {7'b0, q3m}, {7'b0, vecs[i].eq[3]});
      checkOutput($sformatf("v%0d deque8l", i), {7'b0, q8l}, {7'b0, vecs[i].eq[2]});
      checkOutput($sformatf("v%0d deque8m", i), {7'b0, q8m}, {7'b0, vecs[i].eq[1]});
      checkOutput($sformatf("v%0d deque2", i),  {7'b0, q2},  {7'b0, vecs[i].eq[0]});
      @(posedge clk);
      #1;
    end

    // Reset mid-word (8-bit counter sits at 2 here), then count dequeues until
    // the word completes: must restart from slice 0 and take exactly 4.
    reset = 1'b1; deque = 1'b1; d8 = 8'hB4;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset slice0", {6'b0, o8l}, 8'h00);
    n = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      if (c > 1) @(negedge clk);
      if (q8l) begin
        seen = 1'b1;
        n = c;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("post-reset dequeues to done", 8'(n), 8'd4);
    deque = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
